spi_reg_bridge: RTL and testbench



---
 rtl/spi_reg_pkg.sv | 13 +
 rtl/spi_reg_bridge_sync_ff.sv | 24 ++
 rtl/spi_reg_bridge.sv | 162 ++++++++++++++++
 tb/tb_spi_reg_bridge.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the SPI command decoder / register bank.
package spi_reg_pkg;
  localparam int ADDR_W = 7;
  localparam int CMD_WR_BIT = 7;
  localparam logic [ADDR_W-1:0] STATUS_ADDR = 7'h7F;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_WRITE,
    ST_READ
  } state_e;
endpackage

// File: rtl/spi_reg_bridge_sync_ff.sv
// Multi-flop synchroniser for a single asynchronous input; reusable for any CDC bit.
module sync_ff #(
  parameter int   DEPTH     = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_D,
  output logic o_Q
);

  logic [DEPTH-1:0] sync_q;

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      sync_q <= {DEPTH{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[DEPTH-2:0], i_D};
    end
  end

  assign o_Q = sync_q[DEPTH-1];

endmodule

// File: rtl/spi_reg_bridge.sv
// Write / burst-read register protocol on top of the SPI slave byte interface.
// state    | meaning
// ST_IDLE  | no transaction; status byte preloaded every cycle
// ST_CMD   | waiting for the command byte (R/W + start address)
// ST_WRITE | each byte is committed at the pointer
// ST_READ  | each byte returns rdata(pointer)
module spi_reg_bridge
  import spi_reg_pkg::*;
#(
  parameter int         NUM_REGS       = 16,
  parameter logic [7:0] STATUS_BYTE    = 8'hA5,
  parameter int         CS_SYNC_STAGES = 4
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst,
  input  logic                  i_RX_DV,
  input  logic [7:0]            i_RX_Byte,
  output logic                  o_TX_DV,
  output logic [7:0]            o_TX_Byte,
  input  logic                  i_SPI_CS_n,
  input  logic [7:0]            i_Status,
  output logic [NUM_REGS*8-1:0] o_Regs,
  output logic                  o_Wr_Strobe,
  output logic [ADDR_W-1:0]     o_Wr_Addr,
  output logic [7:0]            o_Wr_Data,
  output logic                  o_Busy
);

  localparam int ARM_W = $clog2(CS_SYNC_STAGES + 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d, wr_addr_q, wr_addr_d, rd_addr;
  logic [7:0]        tx_byte_q, tx_byte_d, wr_data_q, wr_data_d, rd_data;
  logic              tx_dv_q, tx_dv_d, wr_stb_q, wr_stb_d;
  logic [7:0]        regs_q [NUM_REGS];
  logic              cs_sync, cs_act, cs_prev_q, cs_rise;
  logic [ARM_W-1:0]  arm_cnt_q;

  sync_ff #(.DEPTH(CS_SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
    .i_Clk (i_Clk),
    .i_Rst (i_Rst),
    .i_D   (i_SPI_CS_n),
    .o_Q   (cs_sync)
  );

  assign cs_act = ~cs_sync;

  // The synchroniser shows its reset value until it refills; holding the edge
  // detector "high" meanwhile stops a CS held low across reset from looking new.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      arm_cnt_q <= ARM_W'(CS_SYNC_STAGES);
      cs_prev_q <= 1'b1;
    end else if (arm_cnt_q != '0) begin
      arm_cnt_q <= arm_cnt_q - ARM_W'(1);
      cs_prev_q <= 1'b1;
    end else begin
      cs_prev_q <= cs_act;
    end
  end

  assign cs_rise = cs_act & ~cs_prev_q;
  assign rd_addr = (state_q == ST_CMD) ? i_RX_Byte[ADDR_W-1:0] : ptr_q;

  always_comb begin
    rd_data = 8'h00;
    for (int n = 0; n < NUM_REGS; n++) begin
      if (rd_addr == ADDR_W'(n)) rd_data = regs_q[n];
    end
    if (rd_addr == STATUS_ADDR) rd_data = i_Status;
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    tx_dv_d   = 1'b0;
    tx_byte_d = tx_byte_q;
    wr_stb_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    case (state_q)
      ST_IDLE: begin
        tx_dv_d   = 1'b1;
        tx_byte_d = STATUS_BYTE;
        if (cs_rise) state_d = ST_CMD;
      end
      ST_CMD: begin
        if (i_RX_DV) begin
          if (i_RX_Byte[CMD_WR_BIT]) begin
            ptr_d   = i_RX_Byte[ADDR_W-1:0];
            state_d = ST_WRITE;
          end else begin
            ptr_d     = i_RX_Byte[ADDR_W-1:0] + 7'd1;
            tx_dv_d   = 1'b1;
            tx_byte_d = rd_data;
            state_d   = ST_READ;
          end
        end
      end
      ST_WRITE: begin
        if (i_RX_DV) begin
          wr_stb_d  = 1'b1;
          wr_addr_d = ptr_q;
          wr_data_d = i_RX_Byte;
          ptr_d     = ptr_q + 7'd1;
        end
      end
      ST_READ: begin
        if (i_RX_DV) begin
          tx_dv_d   = 1'b1;
          tx_byte_d = rd_data;
          ptr_d     = ptr_q + 7'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_q != ST_IDLE && !cs_act) state_d = ST_IDLE;
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      tx_dv_q   <= 1'b0;
      tx_byte_q <= STATUS_BYTE;
      wr_stb_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      tx_dv_q   <= tx_dv_d;
      tx_byte_q <= tx_byte_d;
      wr_stb_q  <= wr_stb_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  // Bank is written from the registered strobe, so o_Regs moves the cycle after it.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      for (int n = 0; n < NUM_REGS; n++) regs_q[n] <= 8'h00;
    end else if (wr_stb_q) begin
      for (int n = 0; n < NUM_REGS; n++) begin
        if (wr_addr_q == ADDR_W'(n)) regs_q[n] <= wr_data_q;
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign o_Regs[g*8 +: 8] = regs_q[g];
  end

  assign o_TX_DV     = tx_dv_q;
  assign o_TX_Byte   = tx_byte_q;
  assign o_Wr_Strobe = wr_stb_q;
  assign o_Wr_Addr   = wr_addr_q;
  assign o_Wr_Data   = wr_data_q;
  assign o_Busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Directed bench for spi_reg_bridge: transaction-level model scheduled per cycle,
// compared every cycle, plus literal checks of the example transactions.
module tb_spi_reg_bridge;
  localparam int         NR    = 16;
  localparam int         STG   = 4;
  localparam logic [7:0] STAT  = 8'hA5;
  localparam int         LAT   = STG + 1;
  localparam int         DEPTH = 4096;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx_dv = 1'b0;
  logic [7:0]    rx_byte = 8'h00;
  logic          cs_n = 1'b1;
  logic [7:0]    status = 8'h5C;
  logic          tx_dv;
  logic [7:0]    tx_byte;
  logic [NR*8-1:0] regs;
  logic          wr_stb;
  logic [6:0]    wr_addr;
  logic [7:0]    wr_data;
  logic          busy;

  always #5 clk = ~clk;

  spi_reg_bridge #(.NUM_REGS(NR), .STATUS_BYTE(STAT), .CS_SYNC_STAGES(STG)) dut (
    .i_Clk(clk), .i_Rst(rst), .i_RX_DV(rx_dv), .i_RX_Byte(rx_byte),
    .o_TX_DV(tx_dv), .o_TX_Byte(tx_byte), .i_SPI_CS_n(cs_n), .i_Status(status),
    .o_Regs(regs), .o_Wr_Strobe(wr_stb), .o_Wr_Addr(wr_addr), .o_Wr_Data(wr_data),
    .o_Busy(busy)
  );

  int cyc;
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // model: per-cycle expectations, indexed by posedges since reset release
  bit         exp_busy  [DEPTH];
  bit         exp_pulse [DEPTH];
  logic [7:0] exp_pbyte [DEPTH];
  bit         exp_stb   [DEPTH];
  logic [6:0] exp_saddr [DEPTH];
  logic [7:0] exp_sdata [DEPTH];
  bit         upd_v     [DEPTH];
  int         upd_a     [DEPTH];
  logic [7:0] upd_d     [DEPTH];
  logic [7:0] mbank     [NR];
  bit         armed;
  int         nbytes;
  bit         m_wr;
  logic [6:0] m_start;

  function automatic logic [7:0] m_rdata(input logic [6:0] a);
    if (int'(a) < NR) return mbank[int'(a)];
    if (a == 7'h7F) return status;
    return 8'h00;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      exp_busy[i] = 0; exp_pulse[i] = 0; exp_pbyte[i] = 8'h00;
      exp_stb[i] = 0; exp_saddr[i] = 7'h00; exp_sdata[i] = 8'h00;
      upd_v[i] = 0; upd_a[i] = 0; upd_d[i] = 8'h00;
    end
    for (int i = 0; i < NR; i++) mbank[i] = 8'h00;
    nbytes = 0;
    armed = cs_n;
  endtask

  int             k;
  bit             exp_dv;
  logic [7:0]     exp_tb;
  logic [NR*8-1:0] flat;
  bit             prev_busy_s = 0;
  logic [7:0]     txq [$];
  logic [14:0]    stbq [$];

  always @(negedge clk) begin
    if (!rst) begin
      k = cyc;
      if (k >= DEPTH - 3) begin
        $display("FAIL cycle_budget cycle %0d exceeds model depth %0d", k, DEPTH);
        $fatal(1);
      end
      if (upd_v[k]) mbank[upd_a[k]] = upd_d[k];
      for (int i = 0; i < NR; i++) flat[i*8 +: 8] = mbank[i];
      chk("regs", regs, flat);
      chk("busy", busy, exp_busy[k]);
      exp_dv = (k == 0) ? 1'b0 : (!exp_busy[k-1] || exp_pulse[k]);
      chk("tx_dv", tx_dv, exp_dv);
      if (k == 0 || exp_dv) begin
        exp_tb = (k != 0 && exp_pulse[k]) ? exp_pbyte[k] : STAT;
        chk("tx_byte", tx_byte, exp_tb);
      end
      chk("wr_strobe", wr_stb, exp_stb[k]);
      if (exp_stb[k]) begin
        chk("wr_addr", wr_addr, exp_saddr[k]);
        chk("wr_data", wr_data, exp_sdata[k]);
      end
      if (tx_dv && prev_busy_s) txq.push_back(tx_byte);
      if (wr_stb) stbq.push_back({wr_addr, wr_data});
      prev_busy_s = busy;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cs_low();
    cs_n = 1'b0;
    if (armed) begin
      for (int i = cyc + LAT; i < DEPTH; i++) exp_busy[i] = 1;
      nbytes = 0;
    end
    armed = 0;
  endtask

  task automatic cs_high();
    cs_n = 1'b1;
    for (int i = cyc + LAT; i < DEPTH; i++) exp_busy[i] = 0;
    armed = 1;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    int n;
    logic [6:0] a;
    n = cyc;
    rx_dv = 1'b1;
    rx_byte = b;
    if (exp_busy[n]) begin
      if (nbytes == 0) begin
        m_wr = b[7];
        m_start = b[6:0];
        if (!m_wr) begin
          exp_pulse[n+1] = 1; exp_pbyte[n+1] = m_rdata(m_start);
        end
      end else if (m_wr) begin
        a = 7'(m_start + 7'(nbytes - 1));
        exp_stb[n+1] = 1; exp_saddr[n+1] = a; exp_sdata[n+1] = b;
        if (int'(a) < NR) begin
          upd_v[n+2] = 1; upd_a[n+2] = int'(a); upd_d[n+2] = b;
        end
      end else begin
        a = 7'(m_start + 7'(nbytes));
        exp_pulse[n+1] = 1; exp_pbyte[n+1] = m_rdata(a);
      end
      nbytes++;
    end
    @(negedge clk);
    rx_dv = 1'b0;
    tick(gap);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_regs", regs, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_tx_dv", tx_dv, 1'b0);
    chk("rst_tx_byte", tx_byte, 8'hA5);
    chk("rst_wr_strobe", wr_stb, 1'b0);
    chk("rst_wr_addr", wr_addr, 7'h00);
    chk("rst_wr_data", wr_data, 8'h00);
    repeat (2) @(posedge clk);
    model_clear();
    #2 rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int l, w;
    @(negedge clk);
    do_reset();
    tick(12);

    // idle status preload and busy latency
    chk("idle_tx_dv", tx_dv, 1'b1);
    chk("idle_tx_byte", tx_byte, 8'hA5);
    cs_low();
    l = cyc;
    w = 0;
    while (!busy && w < 20) begin tick(1); w++; end
    chk("busy_rise_latency", 128'(cyc - l), 128'(LAT));

    // write burst at 3
    stbq.delete();
    tick(4);
    send(8'h83, 10); send(8'h11, 10); send(8'h22, 10);
    cs_high(); tick(12);
    chk("wr_burst_bank", regs, 128'h0000_0000_0000_0000_0000_0022_1100_0000);
    chk("wr_burst_nstb", 128'(stbq.size()), 128'd2);
    if (stbq.size() == 2) begin
      chk("wr_burst_stb0", stbq[0], {7'd3, 8'h11});
      chk("wr_burst_stb1", stbq[1], {7'd4, 8'h22});
    end

    // read burst at 3
    txq.delete();
    cs_low(); tick(10);
    send(8'h03, 10); send(8'h00, 10); send(8'h00, 10);
    cs_high(); tick(12);
    chk("rd_burst_n", 128'(txq.size()), 128'd3);
    if (txq.size() == 3) begin
      chk("rd_burst_0", txq[0], 8'h11);
      chk("rd_burst_1", txq[1], 8'h22);
      chk("rd_burst_2", txq[2], 8'h00);
    end

    // read across unmapped, status and wrap
    txq.delete();
    cs_low(); tick(10);
    send(8'h7E, 10); send(8'h00, 10); send(8'h00, 10);
    cs_high(); tick(12);
    chk("rd_wrap_n", 128'(txq.size()), 128'd3);
    if (txq.size() == 3) begin
      chk("rd_wrap_7e", txq[0], 8'h00);
      chk("rd_wrap_7f", txq[1], 8'h5C);
      chk("rd_wrap_00", txq[2], 8'h00);
    end

    // write across status address and wrap
    stbq.delete();
    cs_low(); tick(10);
    send(8'hFF, 10); send(8'h77, 10); send(8'h88, 10);
    cs_high(); tick(12);
    chk("wr_wrap_nstb", 128'(stbq.size()), 128'd2);
    if (stbq.size() == 2) begin
      chk("wr_wrap_stb0", stbq[0], {7'h7F, 8'h77});
      chk("wr_wrap_stb1", stbq[1], {7'h00, 8'h88});
    end
    chk("wr_wrap_bank", regs, 128'h0000_0000_0000_0000_0000_0022_1100_0088);

    // CS rises together with the last byte
    cs_low(); tick(10);
    send(8'h81, 10);
    cs_high();
    send(8'h9A, 12);
    chk("race_reg1", regs[15:8], 8'h9A);
    chk("race_idle", busy, 1'b0);

    // last byte lands exactly when the synchronised CS drops
    cs_low(); tick(10);
    send(8'h82, 10);
    cs_high();
    tick(STG);
    send(8'h3C, 12);
    chk("edge_reg2", regs[23:16], 8'h3C);

    // zero-byte transaction
    stbq.delete();
    cs_low(); tick(8);
    cs_high(); tick(12);
    chk("zero_byte_nstb", 128'(stbq.size()), 128'd0);

    // reset in the middle of a write burst
    cs_low(); tick(10);
    send(8'h85, 10); send(8'h44, 10);
    do_reset();
    tick(10);
    send(8'h55, 10);
    chk("post_rst_ignored", regs, '0);
    cs_high(); tick(12);
    cs_low(); tick(10);
    send(8'h86, 10); send(8'h66, 10);
    cs_high(); tick(12);
    chk("post_rst_reg6", regs[55:48], 8'h66);
    chk("post_rst_reg5", regs[47:40], 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
